ahb_sram_ws: RTL and testbench

- Parametrised AHB-Lite slave SRAM: successor to the fixed 32-bit single-clock SRAM slave.
- Generalised in data width, depth and programmable wait states; adds byte/halfword write lanes and a two-cycle ERROR response.
- Sits behind the AHB decoder as the on-chip data/instruction RAM of the RISC-V SoC.
- Single clock domain: the memory array is clocked by hclk, with no separate SRAM clock.

---
 rtl/ahb_sram_ws.sv | 214 +++++++++++++++++++++
 tb/tb_ahb_sram_ws.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ws.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ahb_sram_ws
// AHB-Lite slave SRAM with a programmable number of wait states and
// byte/halfword write lanes. It serves as the on-chip data/instruction RAM
// behind the AHB decoder. A single clock domain is used: the array is
// clocked by hclk.
//
// Optional feature macro: AHB_SRAM_ERR_EN
//   defined   : out-of-range or misaligned beats get a two-cycle ERROR
//               response and never touch the array.
//   undefined : hresp_o is constant OKAY. Indexes wrap modulo DEPTH,
//               misaligned addresses are aligned down to the size boundary,
//               and oversized transfers are treated as full width.
//
// Ports
//   hclk        bus clock, all state updates on the rising edge
//   hreset      asynchronous, active-high reset
//   hsel_i      slave select
//   hwrite_i    1 = write, 0 = read
//   hready_i    bus-level ready; an address phase is sampled only when high
//   hsize_i     0 byte, 1 half, 2 word, 3 dword
//   hburst_i    burst type (not interpreted; every beat has its own address)
//   htrans_i    0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//   hwdata_i    write data, valid in the data phase
//   haddr_i     byte address; only the low WINDOW_BITS are decoded
//   hreadyout_o data phase complete
//   hresp_o     00 OKAY, 01 ERROR
//   hrdata_o    read data, zero outside a read data cycle
//
// State | meaning
//   IDLE  | no data phase in progress, ready high
//   WAIT  | data phase stalled, counting down the wait states
//   DATA  | data phase completes this cycle (read data out / write commits)
//   ERR1  | first ERROR cycle, ready low
//   ERR2  | second ERROR cycle, ready high, next address phase allowed
// -----------------------------------------------------------------------------
module ahb_sram_ws #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int WINDOW_BITS = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel_i,
    input  logic                  hwrite_i,
    input  logic                  hready_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [1:0]            htrans_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    input  logic [31:0]           haddr_i,
    output logic                  hreadyout_o,
    output logic [1:0]            hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int LANE_W    = $clog2(NUM_LANES);
    localparam int INDEX_W   = $clog2(DEPTH);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [INDEX_W-1:0]    index_q;
    logic [LANE_W-1:0]     lane_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  addr_phase;
    logic                  accept;
    logic                  beat_err;
    logic                  mem_we;
    logic [NUM_LANES-1:0]  lane_en;

    // Burst type and the undecoded upper address bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{hburst_i, haddr_i};

    assign addr_phase = hsel_i & hready_i & htrans_i[1];

    // WAIT and ERR1 drive ready low, so a well-behaved bus never presents an
    // address phase there; ignoring one keeps a stray hready_i from corrupting
    // the stalled beat.
    assign accept = addr_phase &&
                    ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));

`ifdef AHB_SRAM_ERR_EN
    localparam int                     WB1       = WINDOW_BITS + 1;
    localparam logic [WINDOW_BITS:0]   MEM_BYTES = WB1'(DEPTH * NUM_LANES);

    logic [WINDOW_BITS-1:0] offset;
    logic [LANE_W-1:0]      size_mask;
    logic                   misaligned;
    logic                   out_of_range;

    assign offset = haddr_i[WINDOW_BITS-1:0];

    // Low-order address bits that must be zero for a naturally aligned beat.
    always_comb begin
        size_mask = '0;
        for (int i = 0; i < LANE_W; i++) begin
            size_mask[i] = (int'(hsize_i) > i);
        end
    end

    assign misaligned   = (int'(hsize_i) > LANE_W) || (|(offset[LANE_W-1:0] & size_mask));
    assign out_of_range = {1'b0, offset} >= MEM_BYTES;
    assign beat_err     = misaligned | out_of_range;
`else
    assign beat_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            // IDLE, DATA and ERR2 fall back to IDLE unless a new beat launches below.
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (beat_err) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_d = ST_DATA;
            end else begin
                state_d    = ST_WAIT;
                wait_cnt_d = WAIT_LOAD;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            index_q    <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                index_q <= haddr_i[INDEX_W+LANE_W-1:LANE_W];
                lane_q  <= haddr_i[LANE_W-1:0];
                size_q  <= hsize_i;
                write_q <= hwrite_i;
            end
        end
    end

    // Lane enables: 2^size lanes starting at the byte lane aligned down to the
    // size boundary; anything at or above full width writes every lane.
    always_comb begin
        int eff_size;
        int span;
        int base;
        lane_en  = '0;
        eff_size = (int'(size_q) > LANE_W) ? LANE_W : int'(size_q);
        span     = 1 << eff_size;
        base     = int'(lane_q) & ~(span - 1);
        for (int b = 0; b < NUM_LANES; b++) begin
            if ((b >= base) && (b < base + span)) begin
                lane_en[b] = 1'b1;
            end
        end
    end

    // The array is not reset; the async reset only returns the FSM to IDLE,
    // which also drops any write still waiting for its DATA cycle.
    assign mem_we = (state_q == ST_DATA) && write_q;

    always_ff @(posedge hclk) begin
        if (mem_we) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (lane_en[b]) begin
                    mem[index_q][8*b +: 8] <= hwdata_i[8*b +: 8];
                end
            end
        end
    end

    assign hreadyout_o = !((state_q == ST_WAIT) || (state_q == ST_ERR1));

`ifdef AHB_SRAM_ERR_EN
    assign hresp_o = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
`else
    assign hresp_o = 2'b00;
`endif

    // A write commits at the closing edge of its DATA cycle, so a read in the
    // following beat already sees the new word.
    assign hrdata_o = ((state_q == ST_DATA) && !write_q) ? mem[index_q] : '0;

endmodule

// File: tb/tb_ahb_sram_ws.sv
`timescale 1ns/1ps
module tb_ahb_sram_ws;

    localparam int DW        = 32;
    localparam int NB        = DW / 8;
    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = DEPTH * NB;
    localparam int WS_A      = 0;
    localparam int WS_B      = 3;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    logic        sel, wr, dsel;
    logic [2:0]  size, burst;
    logic [1:0]  trans;
    logic [31:0] addr, wdata;

    logic        rdy_a, rdy_b, rdy;
    logic [1:0]  resp_a, resp_b, resp;
    logic [31:0] rd_a, rd_b, rdata;

    assign rdy   = dsel ? rdy_b  : rdy_a;
    assign resp  = dsel ? resp_b : resp_a;
    assign rdata = dsel ? rd_b   : rd_a;

    ahb_sram_ws #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS_A), .WINDOW_BITS(16)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel_i(sel & ~dsel), .hwrite_i(wr), .hready_i(rdy_a),
        .hsize_i(size), .hburst_i(burst), .htrans_i(trans), .hwdata_i(wdata), .haddr_i(addr),
        .hreadyout_o(rdy_a), .hresp_o(resp_a), .hrdata_o(rd_a)
    );

    ahb_sram_ws #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS_B), .WINDOW_BITS(16)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel_i(sel & dsel), .hwrite_i(wr), .hready_i(rdy_b),
        .hsize_i(size), .hburst_i(burst), .htrans_i(trans), .hwdata_i(wdata), .haddr_i(addr),
        .hreadyout_o(rdy_b), .hresp_o(resp_b), .hrdata_o(rd_b)
    );

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory: one byte array per instance, little-endian.
    logic [7:0] mm [2][MEM_BYTES];

    typedef struct {
        bit          idle;
        bit          seq;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;
    int          data_cycles;

    function automatic bit beat_err(beat_t b);
        int off;
        bit err;
        off = int'(b.addr[15:0]);
        err = (off >= MEM_BYTES) || (b.size > 3'd2) || ((off % (1 << b.size)) != 0);
`ifndef AHB_SRAM_ERR_EN
        err = 1'b0;
`endif
        return err;
    endfunction

    function automatic int eff_addr(beat_t b);
        int off;
        int s;
        off = int'(b.addr[15:0]);
        s   = (b.size > 3'd2) ? 2 : int'(b.size);
        off = off - (off % (1 << s));
        return off % MEM_BYTES;
    endfunction

    function automatic int beat_span(beat_t b);
        return (b.size > 3'd2) ? NB : (1 << b.size);
    endfunction

    function automatic logic [31:0] model_word(int inst, int a);
        int base;
        base = a - (a % NB);
        return {mm[inst][base+3], mm[inst][base+2], mm[inst][base+1], mm[inst][base]};
    endfunction

    task automatic push_beat(input bit w, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] d, input bit sq = 1'b0, input bit idl = 1'b0,
                             input logic [2:0] bu = 3'd0);
        beat_t b;
        b.idle = idl; b.seq = sq; b.write = w; b.addr = a; b.size = s; b.burst = bu; b.data = d;
        q.push_back(b);
    endtask

    task automatic complete(input beat_t b, input int waits);
        bit err;
        int inst;
        int a;
        err  = beat_err(b);
        inst = dsel ? 1 : 0;
        a    = eff_addr(b);
        last_resp = resp;
        check("resp", {30'b0, resp}, err ? 32'd1 : 32'd0);
        check("waits", waits, err ? 1 : (dsel ? WS_B : WS_A));
        if (!err && !b.write) begin
            check("rdata", rdata, model_word(inst, a));
            last_rdata = rdata;
        end else begin
            check("rdata_zero", rdata, 32'd0);
        end
        if (!err && b.write) begin
            for (int k = 0; k < beat_span(b); k++) begin
                mm[inst][a+k] = b.data[8*((a+k)%NB) +: 8];
            end
        end
    endtask

    task automatic drive_addr(input bit v, input beat_t b);
        if (!v) begin
            sel   = 1'b0;
            trans = 2'b00;
        end else begin
            sel   = 1'b1;
            trans = b.idle ? 2'b00 : (b.seq ? 2'b11 : 2'b10);
            wr    = b.write;
            addr  = b.addr;
            size  = b.size;
            burst = b.burst;
        end
    endtask

    // Pipelined master: the next address phase overlaps the current data phase
    // and both advance only when the selected slave reports ready.
    task automatic run_queue();
        beat_t ap, dp;
        bit    ap_v, dp_v;
        int    waits, guard;
        ap_v = 1'b0; dp_v = 1'b0; waits = 0; guard = 0; data_cycles = 0;
        ap = '{default: 0};
        dp = ap;
        @(posedge hclk); #1;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
        drive_addr(ap_v, ap);
        while ((ap_v || dp_v) && guard < 500) begin
            @(negedge hclk);
            guard++;
            if (dp_v) data_cycles++;
            if (!rdy) begin
                waits++;
                check("rdata_wait", rdata, 32'd0);
                if (dp_v) check("resp_wait", {30'b0, resp}, beat_err(dp) ? 32'd1 : 32'd0);
            end else begin
                if (dp_v) complete(dp, waits);
                waits = 0;
                dp_v  = ap_v && !ap.idle;
                dp    = ap;
                ap_v  = 1'b0;
                if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
            end
            @(posedge hclk); #1;
            drive_addr(ap_v, ap);
            wdata = (dp_v && dp.write) ? dp.data : $urandom;
        end
        check("timeout", (guard < 500) ? 32'd0 : 32'd1, 32'd0);
        q.delete();
    endtask

    initial begin
        hreset = 1'b1;
        sel = 1'b0; wr = 1'b0; size = 3'd0; burst = 3'd0; trans = 2'b00;
        addr = 32'd0; wdata = 32'd0; dsel = 1'b0;
        last_rdata = 32'd0; last_resp = 2'b00;

        repeat (2) @(posedge hclk);
        #1;
        check("rst_rdy_a", {31'b0, rdy_a}, 32'd1);
        check("rst_rdy_b", {31'b0, rdy_b}, 32'd1);
        check("rst_resp_a", {30'b0, resp_a}, 32'd0);
        check("rst_rdata_a", rd_a, 32'd0);
        check("rst_rdata_b", rd_b, 32'd0);
        hreset = 1'b0;

        // Known contents for words 0..15 in both instances.
        for (int inst = 0; inst < 2; inst++) begin
            dsel = inst[0];
            for (int w = 0; w < 16; w++) push_beat(1'b1, 32'(w * 4), 3'd2, $urandom);
            run_queue();
        end

        // Zero-wait word writes then reads.
        dsel = 1'b0;
        for (int k = 1; k <= 5; k++) push_beat(1'b1, 32'((k - 1) * 4), 3'd2, 32'h11111111 * 32'(k));
        run_queue();
        for (int k = 1; k <= 5; k++) push_beat(1'b0, 32'((k - 1) * 4), 3'd2, 32'd0);
        run_queue();
        check("word_k5", last_rdata, 32'h55555555);

        // Byte and halfword lanes; the unused data bytes must not leak in.
        push_beat(1'b1, 32'h4, 3'd2, 32'h12345678);
        push_beat(1'b1, 32'h5, 3'd0, 32'hFFFFAB33);
        push_beat(1'b0, 32'h4, 3'd2, 32'd0);
        run_queue();
        check("byte_lane", last_rdata, 32'h1234AB78);
        push_beat(1'b1, 32'h6, 3'd1, 32'hBEEF1234);
        push_beat(1'b0, 32'h4, 3'd2, 32'd0);
        run_queue();
        check("half_lane", last_rdata, 32'hBEEFAB78);

        // Read immediately after write to the same word.
        push_beat(1'b1, 32'h8, 3'd2, 32'hDEADBEEF);
        push_beat(1'b0, 32'h8, 3'd2, 32'd0);
        run_queue();
        check("raw", last_rdata, 32'hDEADBEEF);

`ifdef AHB_SRAM_ERR_EN
        push_beat(1'b1, 32'h1000, 3'd2, 32'hCAFEF00D);
        run_queue();
        check("err_oor_resp", {30'b0, last_resp}, 32'd1);
        push_beat(1'b0, 32'h0, 3'd2, 32'd0);
        run_queue();
        check("err_mem_untouched", last_rdata, 32'h11111111);
        push_beat(1'b1, 32'h3, 3'd1, 32'hFFFFFFFF);
        run_queue();
        check("err_misalign_resp", {30'b0, last_resp}, 32'd1);
        push_beat(1'b0, 32'h0, 3'd2, 32'd0);
        run_queue();
        check("err_mem_untouched2", last_rdata, 32'h11111111);
`else
        push_beat(1'b1, 32'h1000, 3'd2, 32'hCAFEF00D);
        push_beat(1'b0, 32'h0, 3'd2, 32'd0);
        run_queue();
        check("wrap_word0", last_rdata, 32'hCAFEF00D);
`endif

        // Wait-state instance: single read and an INCR4 burst.
        dsel = 1'b1;
        push_beat(1'b0, 32'h4, 3'd2, 32'd0);
        run_queue();
        check("ws3_single_cycles", data_cycles, 32'd4);
        push_beat(1'b0, 32'h10, 3'd2, 32'd0, 1'b0, 1'b0, 3'd3);
        push_beat(1'b0, 32'h14, 3'd2, 32'd0, 1'b1, 1'b0, 3'd3);
        push_beat(1'b0, 32'h18, 3'd2, 32'd0, 1'b1, 1'b0, 3'd3);
        push_beat(1'b0, 32'h1C, 3'd2, 32'd0, 1'b1, 1'b0, 3'd3);
        run_queue();
        check("burst_cycles", data_cycles, 32'd16);

        // Reset in the middle of a stalled write: the write must be dropped.
        push_beat(1'b1, 32'h8, 3'd2, 32'h0BADF00D);
        run_queue();
        @(posedge hclk); #1;
        sel = 1'b1; trans = 2'b10; wr = 1'b1; addr = 32'h8; size = 3'd2;
        @(posedge hclk); #1;
        sel = 1'b0; trans = 2'b00; wdata = 32'hFFFFFFFF;
        @(negedge hclk);
        check("abort_wait_low", {31'b0, rdy}, 32'd0);
        hreset = 1'b1;
        #1;
        check("abort_rst_rdy", {31'b0, rdy}, 32'd1);
        check("abort_rst_resp", {30'b0, resp}, 32'd0);
        check("abort_rst_rdata", rdata, 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        push_beat(1'b0, 32'h8, 3'd2, 32'd0);
        run_queue();
        check("abort_mem_kept", last_rdata, 32'h0BADF00D);

        // Random mix on both instances inside the initialised region.
        for (int inst = 0; inst < 2; inst++) begin
            dsel = inst[0];
            for (int i = 0; i < 60; i++) begin
                logic [31:0] r;
                logic [2:0]  s;
                int          off;
                int          es;
                r   = $urandom;
                s   = (r[3:0] == 4'd0) ? r[6:4] : 3'($urandom_range(0, 2));
                off = $urandom_range(0, 63);
                es  = (s > 3'd2) ? 2 : int'(s);
                if (r[9:8] != 2'd0) off = off & ~((1 << es) - 1);
                push_beat(r[10], {r[31:16], 16'(off)}, s, $urandom, 1'b0, (r[13:11] == 3'd0));
            end
            run_queue();
            for (int w = 0; w < 16; w++) push_beat(1'b0, 32'(w * 4), 3'd2, 32'd0);
            run_queue();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
